// File: rtl/npu_tile_scheduler.sv
// Tile sequencer for one layer on the 4x4 PE array: start, calc, optional activation, SPI load.
// Optional per-wait-state watchdog is built when NPU_TILE_TIMEOUT_EN is defined.
module npu_tile_scheduler #(
  parameter int TILE      = 4,
  parameter int DIM_W     = 8,
  parameter int TO_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_n,
  input  logic             cfg_layer_type,
  input  logic             cfg_act,
  output logic             start,
  output logic             layer_type,
  output logic [DIM_W-1:0] tile_row,
  output logic [DIM_W-1:0] tile_col,
  input  logic             calulcator_valid,
  output logic             add_activation,
  input  logic             neuron_ready,
  output logic             load_to_spi,
  input  logic             transmitted,
  output logic             busy,
  output logic             done,
  output logic [15:0]      tile_count,
  output logic             timeout_err,
  output logic [3:0]       dbg_state_o
);

  // Handshakes: each request output (start, add_activation, load_to_spi) is a one-cycle
  // pulse; its response input is only looked at while in the matching WAIT_* state, and a
  // single-cycle high there completes it. Responses seen in any other state are dropped.
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT_CALC, S_ACT, S_WAIT_ACT, S_LOAD, S_WAIT_TX, S_NEXT, S_DONE
  } state_e;

  localparam logic [DIM_W:0] TILE_M1 = (DIM_W+1)'(TILE - 1);
  localparam logic [DIM_W:0] TILE_W  = (DIM_W+1)'(TILE);

  state_e           state_q, state_d;
  logic             act_q, act_d;
  logic             lt_q, lt_d;
  logic [DIM_W:0]   rows_t_q, rows_t_d;
  logic [DIM_W:0]   cols_t_q, cols_t_d;
  logic [DIM_W-1:0] tile_row_q, tile_row_d;
  logic [DIM_W-1:0] tile_col_q, tile_col_d;
  logic [15:0]      tile_count_q, tile_count_d;
  logic             cfg_ready_q, start_q, add_act_q, load_q, busy_q, done_q;
  logic             timeout_err_q;
  logic             to_expired;
  logic             last_col, last_row;

`ifdef NPU_TILE_TIMEOUT_EN
  localparam int            CNT_W   = $clog2(TO_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt_q;
  logic             is_wait, hs_now;

  always_comb begin
    is_wait = (state_q == S_WAIT_CALC) || (state_q == S_WAIT_ACT) || (state_q == S_WAIT_TX);
    hs_now  = 1'b0;
    case (state_q)
      S_WAIT_CALC: hs_now = calulcator_valid;
      S_WAIT_ACT:  hs_now = neuron_ready;
      S_WAIT_TX:   hs_now = transmitted;
      default:     hs_now = 1'b0;
    endcase
  end
  assign to_expired = is_wait && !hs_now && (to_cnt_q == TO_LAST);
`else
  logic [31:0] to_cycles_unused;
  assign to_cycles_unused = TO_CYCLES;
  assign to_expired       = 1'b0;
`endif

  assign last_col = ({1'b0, tile_col_q} == cols_t_q - 1'b1);
  assign last_row = ({1'b0, tile_row_q} == rows_t_q - 1'b1);

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    lt_d         = lt_q;
    rows_t_d     = rows_t_q;
    cols_t_d     = cols_t_q;
    tile_row_d   = tile_row_q;
    tile_col_d   = tile_col_q;
    tile_count_d = tile_count_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          act_d        = cfg_act;
          lt_d         = cfg_layer_type;
          rows_t_d     = ({1'b0, cfg_m} + TILE_M1) / TILE_W;
          cols_t_d     = ({1'b0, cfg_n} + TILE_M1) / TILE_W;
          tile_row_d   = '0;
          tile_col_d   = '0;
          tile_count_d = '0;
          state_d      = (cfg_m == '0 || cfg_n == '0) ? S_DONE : S_START;
        end
      end
      S_START: state_d = S_WAIT_CALC;
      S_WAIT_CALC: begin
        if (calulcator_valid) state_d = act_q ? S_ACT : S_LOAD;
        else if (to_expired)  state_d = S_DONE;
      end
      S_ACT: state_d = S_WAIT_ACT;
      S_WAIT_ACT: begin
        if (neuron_ready)    state_d = S_LOAD;
        else if (to_expired) state_d = S_DONE;
      end
      S_LOAD: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (transmitted)     state_d = S_NEXT;
        else if (to_expired) state_d = S_DONE;
      end
      S_NEXT: begin
        if (tile_count_q != 16'hFFFF) tile_count_d = tile_count_q + 16'd1;
        if (last_col) begin
          tile_col_d = '0;
          tile_row_d = tile_row_q + 1'b1;
        end else begin
          tile_col_d = tile_col_q + 1'b1;
        end
        state_d = (last_col && last_row) ? S_DONE : S_START;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they decode.
  always_ff @(posedge clk) begin
    if (reset || soft_reset) begin
      state_q      <= S_IDLE;
      act_q        <= 1'b0;
      lt_q         <= 1'b0;
      rows_t_q     <= '0;
      cols_t_q     <= '0;
      tile_row_q   <= '0;
      tile_col_q   <= '0;
      tile_count_q <= '0;
      cfg_ready_q  <= 1'b1;
      start_q      <= 1'b0;
      add_act_q    <= 1'b0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      lt_q         <= lt_d;
      rows_t_q     <= rows_t_d;
      cols_t_q     <= cols_t_d;
      tile_row_q   <= tile_row_d;
      tile_col_q   <= tile_col_d;
      tile_count_q <= tile_count_d;
      cfg_ready_q  <= (state_d == S_IDLE);
      start_q      <= (state_d == S_START);
      add_act_q    <= (state_d == S_ACT);
      load_q       <= (state_d == S_LOAD);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
    end
  end

`ifdef NPU_TILE_TIMEOUT_EN
  // Sticky error survives soft_reset; the counter restarts on every state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
    end else if (soft_reset) begin
      to_cnt_q      <= '0;
    end else begin
      if (to_expired) timeout_err_q <= 1'b1;
      to_cnt_q <= (is_wait && state_d == state_q) ? to_cnt_q + 1'b1 : '0;
    end
  end
`else
  assign timeout_err_q = 1'b0;
`endif

  assign cfg_ready      = cfg_ready_q;
  assign start          = start_q;
  assign layer_type     = lt_q;
  assign tile_row       = tile_row_q;
  assign tile_col       = tile_col_q;
  assign add_activation = add_act_q;
  assign load_to_spi    = load_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign tile_count     = tile_count_q;
  assign timeout_err    = timeout_err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_npu_tile_scheduler.sv
// Directed bench for npu_tile_scheduler: tile order, pulses, latency, resets, ignored inputs.
module tb_npu_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset, soft_reset, cfg_valid, cfg_layer_type, cfg_act;
  logic [7:0] cfg_m, cfg_n;
  logic       calulcator_valid, neuron_ready, transmitted;
  logic       cfg_ready, start, layer_type, add_activation, load_to_spi, busy, done, timeout_err;
  logic [7:0] tile_row, tile_col;
  logic [15:0] tile_count;
  logic [3:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_start = 0, n_act = 0, n_load = 0, n_done = 0;

  npu_tile_scheduler #(.TILE(4), .DIM_W(8), .TO_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_m(cfg_m), .cfg_n(cfg_n),
    .cfg_layer_type(cfg_layer_type), .cfg_act(cfg_act),
    .start(start), .layer_type(layer_type), .tile_row(tile_row), .tile_col(tile_col),
    .calulcator_valid(calulcator_valid), .add_activation(add_activation),
    .neuron_ready(neuron_ready), .load_to_spi(load_to_spi), .transmitted(transmitted),
    .busy(busy), .done(done), .tile_count(tile_count), .timeout_err(timeout_err),
    .dbg_state_o(dbg_state)
  );

  // clock / cycle counter / pulse counters
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (start)          n_start <= n_start + 1;
    if (add_activation) n_act   <= n_act + 1;
    if (load_to_spi)    n_load  <= n_load + 1;
    if (done)           n_done  <= n_done + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_sig(input int s);
    case (s)
      0:       return start;
      1:       return add_activation;
      2:       return load_to_spi;
      3:       return done;
      default: return cfg_ready;
    endcase
  endfunction

  task automatic wait_out(input int s, input string tag, input int max);
    int n = 0;
    while (sel_sig(s) !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(sel_sig(s)), 32'd1);
  endtask

  task automatic send_cfg(input int m, input int n, input logic lt, input logic act);
    wait_out(4, "cfg_ready_wait", 200);
    cfg_m = 8'(m); cfg_n = 8'(n); cfg_layer_type = lt; cfg_act = act;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic run_tile(input int row, input int col, input logic act, input int dly,
                          input logic noise, output int t);
    wait_out(0, "start_wait", 200);
    t = cyc;
    chk("tile_row", 32'(tile_row), 32'(row));
    chk("tile_col", 32'(tile_col), 32'(col));
    tick();
    chk("start_width", 32'(start), 32'd0);
    repeat (dly) tick();
    calulcator_valid = 1'b1; tick(); calulcator_valid = 1'b0;
    if (act) begin
      wait_out(1, "act_wait", 200);
      tick();
      repeat (dly) tick();
      neuron_ready = 1'b1; tick(); neuron_ready = 1'b0;
    end
    wait_out(2, "load_wait", 200);
    tick();
    if (noise) begin
      calulcator_valid = 1'b1; cfg_valid = 1'b1; cfg_m = 8'd0; cfg_n = 8'd0;
      cfg_layer_type = ~cfg_layer_type;
      tick();
      calulcator_valid = 1'b0; cfg_valid = 1'b0;
    end
    repeat (dly) tick();
    transmitted = 1'b1; tick(); transmitted = 1'b0;
  endtask

  initial begin
    int t0, t1, s0, a0, l0, d0;
    reset = 1'b1; soft_reset = 1'b0; cfg_valid = 1'b0; cfg_m = '0; cfg_n = '0;
    cfg_layer_type = 1'b0; cfg_act = 1'b0;
    calulcator_valid = 1'b0; neuron_ready = 1'b0; transmitted = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tile_count", 32'(tile_count), 32'd0);
    chk("rst_tile_row", 32'(tile_row), 32'd0);
    chk("rst_layer_type", 32'(layer_type), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);

    // M=8 N=8 act=1, handshakes delayed 3 cycles
    s0 = n_start; a0 = n_act; l0 = n_load; d0 = n_done;
    send_cfg(8, 8, 1'b1, 1'b1);
    chk("accept_to_start", 32'(start), 32'd1);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("layer_type_latched", 32'(layer_type), 32'd1);
    run_tile(0, 0, 1'b1, 3, 1'b0, t0);
    run_tile(0, 1, 1'b1, 3, 1'b0, t0);
    run_tile(1, 0, 1'b1, 3, 1'b0, t0);
    run_tile(1, 1, 1'b1, 3, 1'b0, t0);
    wait_out(3, "done_8x8", 20);
    chk("count_8x8", 32'(tile_count), 32'd4);
    tick();
    chk("done_width_8x8", 32'(done), 32'd0);
    chk("ready_after_done", 32'(cfg_ready), 32'd1);
    chk("starts_8x8", 32'(n_start - s0), 32'd4);
    chk("acts_8x8", 32'(n_act - a0), 32'd4);
    chk("loads_8x8", 32'(n_load - l0), 32'd4);
    chk("dones_8x8", 32'(n_done - d0), 32'd1);

    // M=5 N=9 act=0 -> 2x3 tiles
    a0 = n_act;
    send_cfg(5, 9, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        run_tile(r, c, 1'b0, 2, 1'b0, t0);
    wait_out(3, "done_5x9", 20);
    chk("count_5x9", 32'(tile_count), 32'd6);
    chk("acts_5x9", 32'(n_act - a0), 32'd0);

    // zero-size layer
    s0 = n_start;
    send_cfg(0, 7, 1'b0, 1'b1);
    chk("zero_done_t1", 32'(done), 32'd1);
    chk("zero_ready_t1", 32'(cfg_ready), 32'd0);
    tick();
    chk("zero_ready_t2", 32'(cfg_ready), 32'd1);
    chk("zero_done_t2", 32'(done), 32'd0);
    chk("zero_no_start", 32'(n_start - s0), 32'd0);

    // stray handshakes and cfg_valid while busy are ignored
    calulcator_valid = 1'b1; tick(); calulcator_valid = 1'b0;
    chk("idle_calc_ignored", 32'(busy), 32'd0);
    send_cfg(4, 8, 1'b1, 1'b0);
    run_tile(0, 0, 1'b0, 3, 1'b1, t0);
    chk("lt_held_busy", 32'(layer_type), 32'd1);
    run_tile(0, 1, 1'b0, 3, 1'b0, t0);
    wait_out(3, "done_noise", 20);
    chk("count_noise", 32'(tile_count), 32'd2);

    // minimum tile period
    send_cfg(8, 4, 1'b0, 1'b1);
    run_tile(0, 0, 1'b1, 0, 1'b0, t0);
    run_tile(1, 0, 1'b1, 0, 1'b0, t1);
    chk("period_act1", 32'(t1 - t0), 32'd7);
    wait_out(3, "done_p7", 20);
    send_cfg(4, 8, 1'b0, 1'b0);
    run_tile(0, 0, 1'b0, 0, 1'b0, t0);
    run_tile(0, 1, 1'b0, 0, 1'b0, t1);
    chk("period_act0", 32'(t1 - t0), 32'd5);
    wait_out(3, "done_p5", 20);

    // M=255 boundary: 64 row tiles
    send_cfg(255, 1, 1'b0, 1'b0);
    for (int r = 0; r < 64; r++) run_tile(r, 0, 1'b0, 0, 1'b0, t0);
    wait_out(3, "done_255", 20);
    chk("count_255", 32'(tile_count), 32'd64);

    // soft_reset in WAIT_ACT of the second tile
    send_cfg(8, 8, 1'b1, 1'b1);
    run_tile(0, 0, 1'b1, 1, 1'b0, t0);
    wait_out(0, "start_t2", 200);
    chk("t2_col", 32'(tile_col), 32'd1);
    tick();
    calulcator_valid = 1'b1; tick(); calulcator_valid = 1'b0;
    wait_out(1, "act_t2", 200);
    tick();
    chk("count_pre_soft", 32'(tile_count), 32'd1);
    soft_reset = 1'b1; tick(); soft_reset = 1'b0;
    chk("soft_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("soft_busy", 32'(busy), 32'd0);
    chk("soft_count", 32'(tile_count), 32'd0);
    chk("soft_col", 32'(tile_col), 32'd0);
    chk("soft_layer_type", 32'(layer_type), 32'd0);
    chk("soft_no_pulse", 32'({add_activation, load_to_spi, start, done}), 32'd0);
    neuron_ready = 1'b1; tick(); neuron_ready = 1'b0;
    chk("idle_nr_ignored", 32'(busy), 32'd0);
    send_cfg(4, 4, 1'b0, 1'b0);
    run_tile(0, 0, 1'b0, 1, 1'b0, t0);
    wait_out(3, "done_after_soft", 20);
    chk("count_after_soft", 32'(tile_count), 32'd1);

    // hard reset mid-layer
    send_cfg(4, 4, 1'b1, 1'b0);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("hard_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("hard_layer_type", 32'(layer_type), 32'd0);
    chk("hard_no_pulse", 32'({start, done, load_to_spi}), 32'd0);

`ifdef NPU_TILE_TIMEOUT_EN
    // watchdog: calculator never answers
    send_cfg(4, 4, 1'b0, 1'b0);
    t0 = cyc;
    wait_out(3, "to_done", 40);
    chk("to_latency", 32'(cyc - t0), 32'd17);
    chk("to_err_set", 32'(timeout_err), 32'd1);
    soft_reset = 1'b1; tick(); soft_reset = 1'b0;
    chk("to_err_soft", 32'(timeout_err), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("to_err_reset", 32'(timeout_err), 32'd0);
`else
    chk("no_to_err", 32'(timeout_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npu_tile_scheduler.md
# npu_tile_scheduler

Sequences one layer of work through the 4x4 PE array, one output tile at a time. Each accepted layer descriptor is split into ceil(M/4) x ceil(N/4) tiles, visited in row-major order. For each tile the block starts the array, waits for the calculator result, optionally runs the activation stage, and hands the tile to the SPI return path. It sits between the SPI-side descriptor source and the array, activation and SPI-load handshakes that the NPU controller exposes.

## Interface
- TILE, 4, PE array edge (tile rows = tile cols = TILE)
- DIM_W, 8, width of layer dimensions M and N
- TO_CYCLES, 1024, watchdog limit per wait state (used only with NPU_TILE_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- soft_reset  in  1  synchronous abort; returns the FSM to IDLE and clears counters, but does not clear timeout_err
- cfg_valid  in  1  layer descriptor valid
- cfg_ready  out  1  high only in IDLE
- cfg_m  in  DIM_W  output rows M
- cfg_n  in  DIM_W  output columns N
- cfg_layer_type  in  1  passed to the array
- cfg_act  in  1  1 = run activation per tile
- start  out  1  one-cycle pulse per tile
- layer_type  out  1  latched cfg_layer_type
- tile_row  out  DIM_W  current tile row index
- tile_col  out  DIM_W  current tile column index
- calulcator_valid  in  1  array result ready
- add_activation  out  1  one-cycle pulse
- neuron_ready  in  1  activation done
- load_to_spi  out  1  one-cycle pulse
- transmitted  in  1  SPI return done
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at the end of the layer
- tile_count  out  16  tiles completed in the current layer
- timeout_err  out  1  sticky watchdog error

## Operation
FSM states: IDLE, START, WAIT_CALC, ACT, WAIT_ACT, LOAD, WAIT_TX, NEXT, DONE.

- **IDLE**
  - cfg_ready=1.
  - On cfg_valid: latch M, N, layer_type and act. Compute rows_t=ceil(M/TILE) and cols_t=ceil(N/TILE). Clear tile_row, tile_col and tile_count.
  - If M=0 or N=0, go to DONE. Otherwise go to START.
- **START**
  - start=1 for exactly this cycle. Go to WAIT_CALC.
- **WAIT_CALC**
  - Stay until calulcator_valid=1.
  - If act=1, go to ACT. Otherwise go to LOAD.
- **ACT**
  - add_activation=1 for this cycle. Go to WAIT_ACT.
- **WAIT_ACT**
  - Stay until neuron_ready=1, then go to LOAD.
- **LOAD**
  - load_to_spi=1 for this cycle. Go to WAIT_TX.
- **WAIT_TX**
  - Stay until transmitted=1, then go to NEXT.
- **NEXT**
  - tile_count increments.
  - If tile_col=cols_t-1: tile_col wraps to 0 and tile_row increments. Otherwise tile_col increments.
  - If this was the last tile (row rows_t-1, col cols_t-1), go to DONE. Otherwise go to START.
- **DONE**
  - done=1 for this cycle. Go to IDLE.
- **Handshake inputs outside their wait state** (calulcator_valid, neuron_ready, transmitted): ignored, not queued.
- **cfg_valid outside IDLE**: ignored. The descriptor is not captured.
- **Dimension arithmetic**: ceil uses (X+TILE-1)/TILE, computed at DIM_W+1 bits so that M=255 gives 64 with no overflow.
- **tile_count**: saturates at 16'hFFFF.

## Timing
- **Reset values** (reset): state=IDLE; cfg_ready=1; all other outputs 0, including layer_type, tile_row, tile_col, tile_count and timeout_err.
- **soft_reset**: same values as reset, except timeout_err holds.
- **Reset priority**: reset wins over soft_reset; both win over all other inputs in the same cycle.
- **Reset mid-operation**: the next cycle is IDLE. No pulse output fires in the cycle after reset.
- **Registered outputs**: all outputs are registered and decoded from the current state.
- **Accept-to-start latency**: cfg accepted at cycle T gives start=1 at T+1.
- **Minimum tile period**: handshake high in the first cycle of each wait state gives 7 cycles with act=1 and 5 with act=0.
- **Last tile**: done asserts 1 cycle after NEXT of the last tile. cfg_ready returns the cycle after done.
- **Zero-size layer**: accepted at T gives done at T+1 and cfg_ready at T+2.

## Configuration
- **NPU_TILE_TIMEOUT_EN defined**:
  - A counter runs in WAIT_CALC, WAIT_ACT and WAIT_TX; it clears on every state entry.
  - When it reaches TO_CYCLES without the awaited handshake, timeout_err is set and the FSM goes to DONE. done pulses and the layer is abandoned.
  - timeout_err clears only on reset.
- **NPU_TILE_TIMEOUT_EN undefined**:
  - No counter is built; wait states wait indefinitely.
  - timeout_err is tied to 0.

## Test plan
- M=8, N=8, act=1, every handshake returned 3 cycles after its request -> 4 start pulses with (row,col) = (0,0),(0,1),(1,0),(1,1); 4 add_activation pulses; 4 load_to_spi pulses; tile_count=4; one done pulse.
- M=5, N=9, act=0 -> rows_t=2, cols_t=3; 6 tiles; no add_activation; done after tile (1,2).
- M=0, N=7 accepted at cycle T -> no start pulse; done at T+1; cfg_ready=1 at T+2.
- calulcator_valid pulsed in IDLE and in WAIT_TX, and cfg_valid pulsed while busy -> all ignored; tile order and tile_count unchanged.
- soft_reset in WAIT_ACT of tile 2, then a new descriptor M=4, N=4 -> IDLE next cycle, tile_count=0; the new layer completes 1 tile.
- With NPU_TILE_TIMEOUT_EN and TO_CYCLES=16, calulcator_valid never arrives -> timeout_err=1 and done pulse after 16 WAIT_CALC cycles; timeout_err survives soft_reset and clears on reset.
